cache_refill_engine: RTL

- Parametrised miss-handling engine between a cache bank array and a wide memory port.
- Refills a full cache line in MEM_WIDTH-sized beats and drains a victim line captured by the write buffer.
- Generalises the fixed two-beat refill/writeback FSM to any beat count.
- Adds a selectable writeback-first or refill-first ordering, and a standalone drain of a pending victim when no miss is outstanding.

---
 rtl/cache_refill_engine.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/cache_refill_engine.sv
// cache_refill_engine
//   Miss-handling engine between a cache bank array and a wide memory port.
//   A missed line is refilled in BEATS = LINE_BITS/MEM_WIDTH beats. A victim
//   line held by the write buffer is drained in the same beat size. WB_FIRST
//   selects whether the victim is drained before or after the refill. With no
//   miss pending, a waiting victim is drained on its own.
//
// Ports
//   clk, rst                       clock (rising edge), synchronous active-high reset
//   miss_valid/ready/addr/set      miss request from the bank (any byte offset)
//   refill_wen/addr/set/data       one-cycle beat write strobe into the bank
//   refill_done                    one-cycle pulse with the last refill beat
//   busy                           engine is not idle
//   wb_valid/addr/data             victim line from the write buffer
//   wb_done                        one-cycle pulse once the victim is written
//   mem_ren/raddr/rdata/rvalid     memory read channel
//   mem_wen/waddr/wdata/wmask/wvalid  memory write channel
//
// Handshake: miss_valid is taken on a rising edge where miss_ready=1.
// mem_ren/mem_wen are requests: address (and write data) stay stable while the
// request is high, and a beat completes on a rising edge where the matching
// mem_rvalid/mem_wvalid is 1. A valid on the channel that is not requesting
// is ignored.
module cache_refill_engine #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int BANK_NUM   = 4,
  parameter int MEM_WIDTH  = 128,
  parameter int WB_FIRST   = 0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            miss_valid,
  output logic                            miss_ready,
  input  logic [ADDR_WIDTH-1:0]           miss_addr,
  input  logic                            miss_set,
  output logic                            refill_wen,
  output logic [ADDR_WIDTH-1:0]           refill_addr,
  output logic                            refill_set,
  output logic [MEM_WIDTH-1:0]            refill_data,
  output logic                            refill_done,
  output logic                            busy,
  input  logic                            wb_valid,
  input  logic [ADDR_WIDTH-1:0]           wb_addr,
  input  logic [BANK_NUM*DATA_WIDTH-1:0]  wb_data,
  output logic                            wb_done,
  output logic                            mem_ren,
  output logic [ADDR_WIDTH-1:0]           mem_raddr,
  input  logic [MEM_WIDTH-1:0]            mem_rdata,
  input  logic                            mem_rvalid,
  output logic                            mem_wen,
  output logic [ADDR_WIDTH-1:0]           mem_waddr,
  output logic [MEM_WIDTH-1:0]            mem_wdata,
  output logic [MEM_WIDTH/8-1:0]          mem_wmask,
  input  logic                            mem_wvalid
);

  localparam int LINE_BITS  = BANK_NUM * DATA_WIDTH;
  localparam int BEATS      = LINE_BITS / MEM_WIDTH;
  localparam int LINE_BYTES = LINE_BITS / 8;
  localparam int BEAT_BYTES = MEM_WIDTH / 8;
  // A single-beat line still gets a 1-bit counter; it is never incremented.
  localparam int CNT_W      = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [CNT_W-1:0]      LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [ADDR_WIDTH-1:0] BEAT_INC  = ADDR_WIDTH'(BEAT_BYTES);
  localparam logic [ADDR_WIDTH-1:0] BASE_MASK = ~ADDR_WIDTH'(LINE_BYTES - 1);

  typedef enum logic [1:0] {IDLE, RD, WB, DONE} state_t;

  state_t                 state;
  logic [CNT_W-1:0]       beat;
  logic [CNT_W-1:0]       next_beat;
  logic [ADDR_WIDTH-1:0]  base;
  logic                   set_q;
  logic                   miss_pending;  // miss accepted, line not yet refilled
  logic [LINE_BITS-1:0]   wb_line;

  assign next_beat = beat + CNT_W'(1);
  assign busy      = (state != IDLE);
  assign mem_wmask = '1;

  // RD and WB both open with a launch cycle (request low) that sets up the
  // first beat. This keeps a done pulse of one phase strictly ahead of the
  // first request of the next phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      beat         <= '0;
      base         <= '0;
      set_q        <= 1'b0;
      miss_pending <= 1'b0;
      wb_line      <= '0;
      miss_ready   <= 1'b1;
      refill_wen   <= 1'b0;
      refill_addr  <= '0;
      refill_set   <= 1'b0;
      refill_data  <= '0;
      refill_done  <= 1'b0;
      wb_done      <= 1'b0;
      mem_ren      <= 1'b0;
      mem_raddr    <= '0;
      mem_wen      <= 1'b0;
      mem_waddr    <= '0;
      mem_wdata    <= '0;
    end else begin
      refill_wen  <= 1'b0;
      refill_done <= 1'b0;
      wb_done     <= 1'b0;
      case (state)
        IDLE: begin
          if (miss_valid) begin
            base         <= miss_addr & BASE_MASK;
            set_q        <= miss_set;
            miss_pending <= 1'b1;
            miss_ready   <= 1'b0;
            state        <= ((WB_FIRST != 0) && wb_valid) ? WB : RD;
          end else if (wb_valid) begin
            miss_ready <= 1'b0;
            state      <= WB;
          end
        end
        RD: begin
          if (!mem_ren) begin
            mem_ren   <= 1'b1;
            mem_raddr <= base;
            beat      <= '0;
          end else if (mem_rvalid) begin
            refill_wen  <= 1'b1;
            refill_addr <= mem_raddr;
            refill_data <= mem_rdata;
            refill_set  <= set_q;
            if (beat == LAST_BEAT) begin
              mem_ren      <= 1'b0;
              refill_done  <= 1'b1;
              beat         <= '0;
              miss_pending <= 1'b0;
              state        <= ((WB_FIRST == 0) && wb_valid) ? WB : DONE;
            end else begin
              beat      <= next_beat;
              mem_raddr <= mem_raddr + BEAT_INC;
            end
          end
        end
        WB: begin
          if (!mem_wen) begin
            mem_wen   <= 1'b1;
            mem_waddr <= wb_addr;
            wb_line   <= wb_data;
            mem_wdata <= wb_data[MEM_WIDTH-1:0];
            beat      <= '0;
          end else if (mem_wvalid) begin
            if (beat == LAST_BEAT) begin
              mem_wen <= 1'b0;
              wb_done <= 1'b1;
              beat    <= '0;
              state   <= miss_pending ? RD : DONE;
            end else begin
              beat      <= next_beat;
              mem_waddr <= mem_waddr + BEAT_INC;
              mem_wdata <= wb_line[int'(next_beat)*MEM_WIDTH +: MEM_WIDTH];
            end
          end
        end
        DONE: begin
          miss_ready <= 1'b1;
          state      <= IDLE;
        end
        default: begin
          miss_ready <= 1'b1;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule
